// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The optional parity stage (UART_RX_PARITY_EN) reuses the PARITY state encoding defined here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int OVERSAMPLE        = 16;
  localparam int MID_SAMPLE        = 7;
  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for a single asynchronous input.
// RESET_VAL lets idle-high lines (such as a UART rx) come out of reset in their idle level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive engine on a 16x oversampling tick: start detect, mid-bit sampling, stop check.
// Define UART_RX_PARITY_EN to add a parity bit stage with parity_odd / parity_err ports.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int SB_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output uart_rx_state_t       state
);

  localparam int S_W = ($clog2(SB_TICKS) > 4) ? $clog2(SB_TICKS) : 4;
  localparam int N_W = $clog2(DATA_BITS);

  localparam logic [S_W-1:0] S_MID  = S_W'(MID_SAMPLE);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICKS - 1);
  localparam logic [S_W-1:0] S_ONE  = S_W'(1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);
  localparam logic [N_W-1:0] N_ONE  = N_W'(1);

  uart_rx_state_t       cur_state;
  logic [S_W-1:0]       s;
  logic [N_W-1:0]       n;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign state = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state    <= IDLE;
      s            <= '0;
      n            <= '0;
      shreg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      case (cur_state)
        // Start edge is taken on any clk; a coincident tick is deliberately not counted.
        IDLE: begin
          if (!rx_s) begin
            cur_state <= START;
            s         <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                cur_state <= DATA;
                s         <= '0;
                n         <= '0;
              end else begin
                cur_state <= IDLE;
              end
            end else begin
              s <= s + S_ONE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == S_LAST) begin
              s     <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                cur_state <= PARITY;
`else
                cur_state <= STOP;
`endif
              end else begin
                n <= n + N_ONE;
              end
            end else begin
              s <= s + S_ONE;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s == S_LAST) begin
              s         <= '0;
              par_bit   <= rx_s;
              cur_state <= STOP;
            end else begin
              s <= s + S_ONE;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s == S_STOP) begin
              dout         <= shreg;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
              cur_state    <= IDLE;
`ifdef UART_RX_PARITY_EN
              // Even parity expects par_bit == ^data; odd flips that expectation.
              parity_err   <= par_bit ^ (^shreg) ^ parity_odd;
`endif
            end else begin
              s <= s + S_ONE;
            end
          end
        end
        default: cur_state <= IDLE;
      endcase
    end
  end

endmodule
